load_split_unit: RTL and testbench

- Parametrised, sequential successor to the core's combinational load path.
- Accepts one load request at a time from the MEM stage and issues one or two aligned bus reads.
- Stitches beats across a word boundary, then shifts, trims and sign/zero-extends the result.
- Returns the result over a valid/ready response channel, flagging misaligned-trap or bus error.

---
 rtl/load_pkg.sv | 39 +++
 rtl/load_split_unit_if.sv | 45 ++++
 rtl/load_align.sv | 35 +++
 rtl/load_split_unit.sv | 150 +++++++++++++++
 tb/tb_load_split_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// Shared types and byte-lane helpers for the split load unit.
// Lane helpers are written for beats of up to 8 bytes, so they serve both XLEN settings.
package load_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } load_size_e;

  typedef logic [2:0] load_state_e;

  localparam load_state_e S_IDLE  = 3'd0;
  localparam load_state_e S_REQ0  = 3'd1;
  localparam load_state_e S_WAIT0 = 3'd2;
  localparam load_state_e S_REQ1  = 3'd3;
  localparam load_state_e S_WAIT1 = 3'd4;
  localparam load_state_e S_RESP  = 3'd5;

  // Byte window of the access across two beats.
  // Bits [NB-1:0] are the beat0 strobes and bits [2NB-1:NB] are the beat1 strobes.
  function automatic logic [15:0] byte_window(input logic [2:0] off, input load_size_e size);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    return m << off;
  endfunction

  function automatic logic crosses(input logic [2:0] off, input load_size_e size,
                                   input int unsigned nb);
    return (32'(off) + (32'd1 << size)) > nb;
  endfunction

  // For size 3, 1<<3 wraps to 0 in 3 bits, so the mask becomes 7: exactly the 8-byte rule.
  function automatic logic misaligned(input logic [2:0] off, input load_size_e size);
    return (off & ((3'd1 << size) - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/load_split_unit_if.sv
// Request, bus-read and response channels of the split load unit.
interface load_split_unit_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] req_addr_i;
    logic [1:0]      req_size_i;
    logic            req_unsigned_i;

    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic [XLEN-1:0] mem_addr_o;
    logic [NB-1:0]   mem_rstrb_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_data_o;
    logic            rsp_misaligned_o;
    logic            rsp_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_size_i, req_unsigned_i,
        output req_ready_o,
        output mem_req_valid_o, mem_addr_o, mem_rstrb_o,
        input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output rsp_valid_o, rsp_data_o, rsp_misaligned_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_addr_i, req_size_i, req_unsigned_i,
        input  req_ready_o,
        input  mem_req_valid_o, mem_addr_o, mem_rstrb_o,
        output mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  rsp_valid_o, rsp_data_o, rsp_misaligned_o, rsp_err_o,
        output rsp_ready_i
    );

endinterface

// File: rtl/load_align.sv
// Stitches two beats, shifts the addressed bytes down, then trims and extends them to XLEN.
module load_align
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              i_beat0,
    input  logic [XLEN-1:0]              i_beat1,
    input  logic [$clog2(XLEN/8)-1:0]    i_off,
    input  load_size_e                   i_size,
    input  logic                         i_unsigned,
    output logic [XLEN-1:0]              o_data
);

    logic [2*XLEN-1:0] w_sh;
    logic [XLEN-1:0]   w_mask;
    logic              w_msb;

    assign w_sh = {i_beat1, i_beat0} >> {i_off, 3'b000};

    // A dword needs no mask; with XLEN=32 it never reaches here without an error flag.
    always_comb begin
        w_mask = '1;
        w_msb  = w_sh[63];
        case (i_size)
            SZ_BYTE: begin w_mask = XLEN'(8'hFF);         w_msb = w_sh[7];  end
            SZ_HALF: begin w_mask = XLEN'(16'hFFFF);      w_msb = w_sh[15]; end
            SZ_WORD: begin w_mask = XLEN'(32'hFFFF_FFFF); w_msb = w_sh[31]; end
            default: begin w_mask = '1;                   w_msb = w_sh[63]; end
        endcase
    end

    assign o_data = (w_sh[XLEN-1:0] & w_mask) | ({XLEN{w_msb & ~i_unsigned}} & ~w_mask);

endmodule

// File: rtl/load_split_unit.sv
// Sequential load path: takes one request, issues one or two aligned bus reads,
// then returns the extended result or a trap/error flag on a valid/ready channel.
module load_split_unit
    import load_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    load_split_unit_if.slave   bus
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    load_state_e     r_state;
    logic            r_live;
    logic [XLEN-1:0] r_addr;
    load_size_e      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_beat0;
    logic [XLEN-1:0] r_beat1;
    logic            r_err;
    logic            r_mis;

    logic [OFFW-1:0] w_in_off;
    load_size_e      w_in_size;
    logic            w_in_illegal;
    logic            w_in_mis;
    logic            w_ready;
    logic            w_accept;
    logic [OFFW-1:0] w_off;
    logic [2*NB-1:0] w_win;
    logic            w_cross;
    logic [XLEN-1:0] w_base;
    logic            w_resp;
    logic [XLEN-1:0] w_data;

    assign w_in_off     = bus.req_addr_i[OFFW-1:0];
    assign w_in_size    = load_size_e'(bus.req_size_i);
    assign w_in_illegal = (XLEN == 32) && (w_in_size == SZ_DWORD);
    assign w_in_mis     = misaligned(3'(w_in_off), w_in_size);

    // r_live keeps req_ready_o low while reset is asserted even though the state is IDLE.
    assign w_ready  = r_live && (r_state == S_IDLE);
    assign w_accept = w_ready && bus.req_valid_i;

    assign w_off   = r_addr[OFFW-1:0];
    assign w_win   = (2*NB)'(byte_window(3'(w_off), r_size));
    assign w_cross = crosses(3'(w_off), r_size, NB);
    assign w_base  = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign w_resp  = (r_state == S_RESP);

    load_align #(.XLEN(XLEN)) u_align (
        .i_beat0    (r_beat0),
        .i_beat1    (r_beat1),
        .i_off      (w_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_data)
    );

    assign bus.req_ready_o     = w_ready;
    assign bus.mem_req_valid_o = (r_state == S_REQ0) || (r_state == S_REQ1);

    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_rstrb_o = '0;
        case (r_state)
            S_REQ0: begin
                bus.mem_addr_o  = w_base;
                bus.mem_rstrb_o = w_win[NB-1:0];
            end
            S_REQ1: begin
                bus.mem_addr_o  = w_base + XLEN'(NB);
                bus.mem_rstrb_o = w_win[2*NB-1:NB];
            end
            default: ;
        endcase
    end

    assign bus.rsp_valid_o      = w_resp;
    assign bus.rsp_err_o        = w_resp && r_err;
    assign bus.rsp_misaligned_o = w_resp && r_mis;
    assign bus.rsp_data_o       = (w_resp && !r_err && !r_mis) ? w_data : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_live     <= 1'b0;
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_beat0    <= '0;
            r_beat1    <= '0;
            r_err      <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.req_addr_i;
                        r_size     <= w_in_size;
                        r_unsigned <= bus.req_unsigned_i;
                        r_beat0    <= '0;
                        r_beat1    <= '0;
                        r_err      <= w_in_illegal;
                        r_mis      <= 1'b0;
                        if (w_in_illegal) begin
                            r_state <= S_RESP;
                        end else if (w_in_mis && !SUPPORT_MISALIGNED) begin
                            r_mis   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_REQ0;
                        end
                    end
                end
                S_REQ0: if (bus.mem_req_ready_i) r_state <= S_WAIT0;
                S_WAIT0: begin
                    if (bus.mem_rvalid_i) begin
                        r_beat0 <= bus.mem_rdata_i;
                        // A faulting first beat ends the access; the second beat is never issued.
                        if (bus.mem_err_i) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (w_cross) begin
                            r_state <= S_REQ1;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_REQ1: if (bus.mem_req_ready_i) r_state <= S_WAIT1;
                S_WAIT1: begin
                    if (bus.mem_rvalid_i) begin
                        r_beat1 <= bus.mem_rdata_i;
                        r_err   <= r_err | bus.mem_err_i;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: if (bus.rsp_ready_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_split_unit.sv
// Scoreboard bench for load_split_unit (XLEN=32): a split-capable unit and a trapping unit.
module tb_load_split_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        mis;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_split_unit_if #(.XLEN(32)) if0 ();
    load_split_unit_if #(.XLEN(32)) if1 ();

    load_split_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1'b1)) dut0 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if0)
    );
    load_split_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1'b0)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if1)
    );

    beat_t beat_q[$];
    rsp_t  exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                             input logic e);
        beat_t b;
        b.addr = a; b.strb = s; b.rdata = d; b.err = e;
        beat_q.push_back(b);
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic e, input logic m);
        rsp_t r;
        r.data = d; r.err = e; r.mis = m;
        exp_q.push_back(r);
    endtask

    // Drives one request into dut0 and plays the memory side from beat_q.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input int hold, input int exp_lat);
        beat_t       b;
        rsp_t        r;
        int          lat;
        int          wn;
        bit          pend;
        bit          done;
        logic [31:0] pdata;
        logic        perr;
        @(negedge clk);
        if0.req_valid_i    = 1'b1;
        if0.req_addr_i     = addr;
        if0.req_size_i     = size;
        if0.req_unsigned_i = uns;
        wn = 0;
        while (!if0.req_ready_o && wn < 20) begin @(negedge clk); wn++; end
        chk("req_ready", 32'(if0.req_ready_o), 32'd1);
        @(negedge clk);
        if0.req_valid_i = 1'b0;
        lat = 1; pend = 0; done = 0; pdata = '0; perr = 1'b0;
        while (!done && lat < 50) begin
            if0.mem_rvalid_i = pend;
            if0.mem_rdata_i  = pend ? pdata : 32'h0;
            if0.mem_err_i    = pend & perr;
            pend = 0;
            if (if0.mem_req_valid_o) begin
                if (beat_q.size() == 0) begin
                    chk("beat expected", 32'(beat_q.size()), 32'd1);
                    pdata = 32'h0; perr = 1'b0;
                end else begin
                    b = beat_q.pop_front();
                    chk("mem_addr", if0.mem_addr_o, b.addr);
                    chk("mem_strb", 32'(if0.mem_rstrb_o), 32'(b.strb));
                    pdata = b.rdata; perr = b.err;
                end
                pend = 1;
            end
            if (if0.rsp_valid_o) begin
                chk("latency", 32'(lat), 32'(exp_lat));
                if (exp_q.size() == 0) begin
                    chk("rsp expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    r = exp_q.pop_front();
                    for (int k = 0; k < hold; k++) begin
                        @(negedge clk);
                        chk("hold valid", 32'(if0.rsp_valid_o), 32'd1);
                        chk("hold data", if0.rsp_data_o, r.data);
                    end
                    chk("rsp_data", if0.rsp_data_o, r.data);
                    chk("rsp_err", 32'(if0.rsp_err_o), 32'(r.err));
                    chk("rsp_mis", 32'(if0.rsp_misaligned_o), 32'(r.mis));
                end
                if0.rsp_ready_i = 1'b1;
                @(negedge clk);
                if0.rsp_ready_i = 1'b0;
                chk("rsp drop", 32'(if0.rsp_valid_o), 32'd0);
                done = 1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!done) chk("rsp timeout", 32'(done), 32'd1);
        chk("beats consumed", 32'(beat_q.size()), 32'd0);
        if0.mem_rvalid_i = 1'b0;
        if0.mem_err_i    = 1'b0;
    endtask

    // Byte-array reference for a random load at 0x400..0x40F.
    task automatic rand_load();
        logic [31:0] addr, w0, w1, val;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  bb[8];
        logic [3:0]  s0, s1;
        logic [63:0] m;
        int          off, n, p;
        addr = 32'h400 + 32'($urandom_range(0, 15));
        size = 2'($urandom_range(0, 2));
        uns  = 1'($urandom_range(0, 1));
        w0   = $urandom;
        w1   = $urandom;
        off  = int'(addr[1:0]);
        n    = 1 << size;
        for (int i = 0; i < 4; i++) begin
            bb[i]   = w0[8*i +: 8];
            bb[4+i] = w1[8*i +: 8];
        end
        val = 32'h0; s0 = 4'h0; s1 = 4'h0;
        for (int i = 0; i < n; i++) begin
            p = off + i;
            val = val | (32'(bb[p]) << (8*i));
            if (p < 4) s0[p] = 1'b1; else s1[p-4] = 1'b1;
        end
        m = (64'd1 << (8*n)) - 64'd1;
        if (!uns && bb[off+n-1][7]) val = val | ~m[31:0];
        push_beat({addr[31:2], 2'b00}, s0, w0, 1'b0);
        if (s1 != 4'h0) push_beat({addr[31:2], 2'b00} + 32'd4, s1, w1, 1'b0);
        push_rsp(val, 1'b0, 1'b0);
        do_load(addr, size, uns, 0, (s1 != 4'h0) ? 5 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

    initial begin
        if0.req_valid_i = 0; if0.req_addr_i = 0; if0.req_size_i = 0; if0.req_unsigned_i = 0;
        if0.mem_req_ready_i = 1; if0.mem_rvalid_i = 0; if0.mem_rdata_i = 0; if0.mem_err_i = 0;
        if0.rsp_ready_i = 0;
        if1.req_valid_i = 0; if1.req_addr_i = 0; if1.req_size_i = 0; if1.req_unsigned_i = 0;
        if1.mem_req_ready_i = 1; if1.mem_rvalid_i = 0; if1.mem_rdata_i = 0; if1.mem_err_i = 0;
        if1.rsp_ready_i = 0;

        #7;
        chk("reset req_ready", 32'(if0.req_ready_o), 32'd0);
        chk("reset mem_req_valid", 32'(if0.mem_req_valid_o), 32'd0);
        chk("reset mem_addr", if0.mem_addr_o, 32'd0);
        chk("reset rsp_valid", 32'(if0.rsp_valid_o), 32'd0);
        chk("reset rsp_data", if0.rsp_data_o, 32'd0);
        chk("reset1 req_ready", 32'(if1.req_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LW aligned
        push_beat(32'h100, 4'hF, 32'hDEADBEEF, 1'b0);
        push_rsp(32'hDEADBEEF, 1'b0, 1'b0);
        do_load(32'h100, 2'd2, 1'b0, 0, 3);
        // LB / LBU top byte
        push_beat(32'h100, 4'h8, 32'h80112233, 1'b0);
        push_rsp(32'hFFFFFF80, 1'b0, 1'b0);
        do_load(32'h103, 2'd0, 1'b0, 0, 3);
        push_beat(32'h100, 4'h8, 32'h80112233, 1'b0);
        push_rsp(32'h00000080, 1'b0, 1'b0);
        do_load(32'h103, 2'd0, 1'b1, 0, 3);
        // LH misaligned within one beat
        push_beat(32'h100, 4'h6, 32'h00ABCD00, 1'b0);
        push_rsp(32'hFFFFABCD, 1'b0, 1'b0);
        do_load(32'h101, 2'd1, 1'b0, 0, 3);
        // LW split with a stalled consumer
        push_beat(32'h100, 4'hC, 32'hAABBCCDD, 1'b0);
        push_beat(32'h104, 4'h3, 32'h11223344, 1'b0);
        push_rsp(32'h3344AABB, 1'b0, 1'b0);
        do_load(32'h102, 2'd2, 1'b0, 4, 5);
        // LH / LHU split at the last byte of a word
        push_beat(32'h200, 4'h8, 32'h11000000, 1'b0);
        push_beat(32'h204, 4'h1, 32'h000000FF, 1'b0);
        push_rsp(32'h0000FF11, 1'b0, 1'b0);
        do_load(32'h203, 2'd1, 1'b1, 0, 5);
        push_beat(32'h200, 4'h8, 32'h11000000, 1'b0);
        push_beat(32'h204, 4'h1, 32'h000000FF, 1'b0);
        push_rsp(32'hFFFFFF11, 1'b0, 1'b0);
        do_load(32'h203, 2'd1, 1'b0, 0, 5);
        // Split with a bus error on beat0: no second beat
        push_beat(32'h104, 4'hC, 32'h12345678, 1'b1);
        push_rsp(32'h0, 1'b1, 1'b0);
        do_load(32'h106, 2'd2, 1'b0, 0, 3);
        // Dword on a 32-bit unit is illegal
        push_rsp(32'h0, 1'b1, 1'b0);
        do_load(32'h100, 2'd3, 1'b0, 0, 1);

        for (int i = 0; i < 10; i++) rand_load();

        // Trapping unit: misaligned LW never touches the bus
        @(negedge clk);
        if1.req_valid_i = 1'b1; if1.req_addr_i = 32'h102; if1.req_size_i = 2'd2;
        chk("trap req_ready", 32'(if1.req_ready_o), 32'd1);
        @(negedge clk);
        if1.req_valid_i = 1'b0;
        chk("trap mem_req_valid", 32'(if1.mem_req_valid_o), 32'd0);
        chk("trap rsp_valid", 32'(if1.rsp_valid_o), 32'd1);
        chk("trap misaligned", 32'(if1.rsp_misaligned_o), 32'd1);
        chk("trap err", 32'(if1.rsp_err_o), 32'd0);
        chk("trap data", if1.rsp_data_o, 32'd0);
        if1.rsp_ready_i = 1'b1;
        @(negedge clk);
        if1.rsp_ready_i = 1'b0;
        chk("trap rsp drop", 32'(if1.rsp_valid_o), 32'd0);
        chk("trap no bus", 32'(if1.mem_req_valid_o), 32'd0);

        // Reset while the second beat of a split load is outstanding
        @(negedge clk);
        if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h102; if0.req_size_i = 2'd2;
        if0.req_unsigned_i = 1'b0;
        @(negedge clk);
        if0.req_valid_i = 1'b0;
        chk("rst REQ0", 32'(if0.mem_req_valid_o), 32'd1);
        @(negedge clk);
        if0.mem_rvalid_i = 1'b1; if0.mem_rdata_i = 32'hAABBCCDD;
        @(negedge clk);
        if0.mem_rvalid_i = 1'b0;
        chk("rst REQ1 addr", if0.mem_addr_o, 32'h104);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst req_ready", 32'(if0.req_ready_o), 32'd0);
        chk("rst mem_req_valid", 32'(if0.mem_req_valid_o), 32'd0);
        chk("rst mem_addr", if0.mem_addr_o, 32'd0);
        chk("rst rsp_valid", 32'(if0.rsp_valid_o), 32'd0);
        chk("rst rsp_data", if0.rsp_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if0.mem_rvalid_i = 1'b1; if0.mem_rdata_i = 32'h11223344;
        @(negedge clk);
        if0.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale rsp_valid", 32'(if0.rsp_valid_o), 32'd0);
            chk("stale mem_req", 32'(if0.mem_req_valid_o), 32'd0);
            @(negedge clk);
        end
        chk("post-reset ready", 32'(if0.req_ready_o), 32'd1);

        push_beat(32'h300, 4'hF, 32'hCAFEF00D, 1'b0);
        push_rsp(32'hCAFEF00D, 1'b0, 1'b0);
        do_load(32'h300, 2'd2, 1'b0, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
